// File: rtl/program_sequencer.sv
// Program sequencer: fetch PC generation with prioritised redirects
// (trap, mret, branch, jump, return), a circular return-address stack,
// a one-cycle FLUSH after every redirect, and a HALT state.
module program_sequencer #(
  parameter int unsigned                 INSTR_ADDR_WIDTH = 20,
  parameter int unsigned                 STEP             = 2,
  parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_VECTOR     = '0,
  parameter logic [INSTR_ADDR_WIDTH-1:0] TRAP_VECTOR      = INSTR_ADDR_WIDTH'('h100),
  parameter int unsigned                 RAS_DEPTH        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_ready,
  input  logic                        stall,
  input  logic                        branch_taken,
  input  logic [INSTR_ADDR_WIDTH-1:0] branch_target,
  input  logic                        jump,
  input  logic [INSTR_ADDR_WIDTH-1:0] jump_target,
  input  logic                        link,
  input  logic                        ret,
  input  logic                        trap_req,
  input  logic                        mret,
  input  logic                        halt_req,
  input  logic                        resume,
  output logic [INSTR_ADDR_WIDTH-1:0] pc,
  output logic [INSTR_ADDR_WIDTH-1:0] pc_plus,
  output logic [INSTR_ADDR_WIDTH-1:0] pc_next,
  output logic                        fetch_valid,
  output logic [INSTR_ADDR_WIDTH-1:0] epc,
  output logic [1:0]                  state,
  output logic                        misaligned,
  output logic                        ras_empty,
  output logic                        ras_full
);

  localparam int unsigned W     = INSTR_ADDR_WIDTH;
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);
  localparam logic [W-1:0]     INC        = W'(1) << STEP;
  localparam logic [W-1:0]     ALIGN_MASK = INC - W'(1);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  logic [W-1:0]     pc_q, pc_d;
  logic [W-1:0]     epc_q, epc_d;
  logic [1:0]       state_q, state_d;
  logic             mis_q, mis_d;
  logic [PTR_W-1:0] sp_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     ras_q [RAS_DEPTH];

  logic             push, pop;
  logic [W-1:0]     ras_top;
  logic [W-1:0]     seq_pc;

  function automatic logic is_misaligned(input logic [W-1:0] addr);
    return |(addr & ALIGN_MASK);
  endfunction

  assign seq_pc  = pc_q + INC;
  assign ras_top = ras_q[sp_q - PTR_W'(1)];

  // Next-state selection: redirect priority, halt handling and stall freeze
  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    state_d = state_q;
    mis_d   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    if (!stall) begin
      case (state_q)
        RUN: begin
          if (trap_req) begin
            epc_d   = pc_q;
            pc_d    = TRAP_VECTOR;
            state_d = FLUSH;
          end else if (mret) begin
            pc_d    = epc_q;
            state_d = FLUSH;
          end else if (branch_taken) begin
            state_d = FLUSH;
            if (is_misaligned(branch_target)) begin
              epc_d = pc_q;
              pc_d  = TRAP_VECTOR;
              mis_d = 1'b1;
            end else begin
              pc_d = branch_target;
            end
          end else if (jump) begin
            // A misaligned call becomes a trap, so its return address is not pushed
            state_d = FLUSH;
            if (is_misaligned(jump_target)) begin
              epc_d = pc_q;
              pc_d  = TRAP_VECTOR;
              mis_d = 1'b1;
            end else begin
              pc_d = jump_target;
              push = link;
            end
          end else if (ret && (cnt_q != '0)) begin
            // The popped entry is consumed even when it turns into a trap
            state_d = FLUSH;
            pop     = 1'b1;
            if (is_misaligned(ras_top)) begin
              epc_d = pc_q;
              pc_d  = TRAP_VECTOR;
              mis_d = 1'b1;
            end else begin
              pc_d = ras_top;
            end
          end else if (halt_req) begin
            state_d = HALT;
          end else if (fetch_ready) begin
            pc_d = seq_pc;
          end
        end
        FLUSH: begin
          state_d = halt_req ? HALT : RUN;
        end
        HALT: begin
          if (trap_req) begin
            epc_d   = pc_q;
            pc_d    = TRAP_VECTOR;
            state_d = FLUSH;
          end else if (resume) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // PC, EPC, state and misalignment pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      state_q <= RUN;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      state_q <= state_d;
      mis_q   <= mis_d;
    end
  end

  // Stack pointer and occupancy; a push when full wraps onto the oldest slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else if (push) begin
      sp_q  <= sp_q + PTR_W'(1);
      cnt_q <= (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
    end else if (pop) begin
      sp_q  <= sp_q - PTR_W'(1);
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Return-address storage; contents are only meaningful below the count
  always_ff @(posedge clk) begin
    if (push) begin
      ras_q[sp_q] <= seq_pc;
    end
  end

  assign pc          = pc_q;
  assign pc_plus     = seq_pc;
  assign pc_next     = pc_d;
  assign fetch_valid = (state_q == RUN);
  assign epc         = epc_q;
  assign state       = state_q;
  assign misaligned  = mis_q;
  assign ras_empty   = (cnt_q == '0);
  assign ras_full    = (cnt_q == CNT_FULL);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer (default parameters).
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready, stall, branch_taken, jump, link, ret;
  logic        trap_req, mret, halt_req, resume;
  logic [19:0] branch_target, jump_target;
  logic [19:0] pc, pc_plus, pc_next, epc;
  logic        fetch_valid, misaligned, ras_empty, ras_full;
  logic [1:0]  state;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  program_sequencer #(
    .INSTR_ADDR_WIDTH(20),
    .STEP(2),
    .RESET_VECTOR(20'h0),
    .TRAP_VECTOR(20'h100),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .link(link), .ret(ret),
    .trap_req(trap_req), .mret(mret), .halt_req(halt_req), .resume(resume),
    .pc(pc), .pc_plus(pc_plus), .pc_next(pc_next), .fetch_valid(fetch_valid),
    .epc(epc), .state(state), .misaligned(misaligned),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    branch_taken = 1'b0; jump = 1'b0; link = 1'b0; ret = 1'b0;
    trap_req = 1'b0; mret = 1'b0; halt_req = 1'b0; resume = 1'b0;
    stall = 1'b0;
  endtask

  // Unlinked jump followed by its FLUSH cycle, ending in RUN at dest
  task automatic goto(input logic [19:0] dest);
    jump = 1'b1; jump_target = dest;
    tick();
    jump = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; fetch_ready = 1'b0;
    branch_target = '0; jump_target = '0;
    clear_req();
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_state", state, 32'h0);
    chk("rst_empty", ras_empty, 32'h1);
    chk("rst_full", ras_full, 32'h0);
    chk("rst_mis", misaligned, 32'h0);
    tick(); tick();
    rst = 1'b0;
    chk("rel_pc", pc, 32'h0);
    chk("rel_fv", fetch_valid, 32'h1);

    // Sequential fetch 0 -> 4 -> 8 -> C
    fetch_ready = 1'b1;
    tick(); chk("seq_pc1", pc, 32'h4); chk("seq_fv1", fetch_valid, 32'h1);
    tick(); chk("seq_pc2", pc, 32'h8); chk("seq_fv2", fetch_valid, 32'h1);
    tick(); chk("seq_pc3", pc, 32'hC); chk("seq_fv3", fetch_valid, 32'h1);
    chk("seq_plus", pc_plus, 32'h10);
    chk("seq_next", pc_next, 32'h10);
    tick(); chk("seq_pc4", pc, 32'h10);

    // Branch with fetch_ready low still redirects, then one FLUSH cycle
    fetch_ready = 1'b0; branch_taken = 1'b1; branch_target = 20'h40;
    #1 chk("br_next", pc_next, 32'h40);
    tick();
    branch_taken = 1'b0;
    chk("br_pc", pc, 32'h40);
    chk("br_state", state, 32'h1);
    chk("br_fv", fetch_valid, 32'h0);
    tick();
    chk("br_run", state, 32'h0);
    chk("br_fv2", fetch_valid, 32'h1);
    chk("br_hold", pc, 32'h40);

    // Trap beats branch; mret returns to epc
    goto(20'h20);
    chk("tr_at", pc, 32'h20);
    trap_req = 1'b1; branch_taken = 1'b1; branch_target = 20'h40;
    tick();
    clear_req();
    chk("tr_pc", pc, 32'h100);
    chk("tr_epc", epc, 32'h20);
    chk("tr_state", state, 32'h1);
    tick();
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk("mret_pc", pc, 32'h20);
    tick();

    // Five linked calls into a 4-deep stack, then unwind
    goto(20'h0);
    for (int k = 0; k < 5; k++) begin
      jump = 1'b1; link = 1'b1;
      jump_target = (k == 4) ? 20'h80 : 20'((k + 1) * 16);
      tick();
      jump = 1'b0; link = 1'b0;
      tick();
    end
    chk("call_pc", pc, 32'h80);
    chk("ras_full", ras_full, 32'h1);
    chk("ras_nempty", ras_empty, 32'h0);
    ret = 1'b1; tick(); ret = 1'b0; chk("ret1", pc, 32'h44); tick();
    ret = 1'b1; tick(); ret = 1'b0; chk("ret2", pc, 32'h34); tick();
    ret = 1'b1; tick(); ret = 1'b0; chk("ret3", pc, 32'h24); tick();
    ret = 1'b1; tick(); ret = 1'b0; chk("ret4", pc, 32'h14); tick();
    chk("ras_empty", ras_empty, 32'h1);
    ret = 1'b1; tick(); ret = 1'b0;
    chk("ret5_pc", pc, 32'h14);
    chk("ret5_state", state, 32'h0);
    chk("ret5_empty", ras_empty, 32'h1);

    // Misaligned jump converts to a trap with a one-cycle pulse
    jump = 1'b1; jump_target = 20'h42;
    tick();
    jump = 1'b0;
    chk("mis_pulse", misaligned, 32'h1);
    chk("mis_pc", pc, 32'h100);
    chk("mis_epc", epc, 32'h14);
    tick();
    chk("mis_clear", misaligned, 32'h0);
    chk("mis_run", state, 32'h0);

    // Halt / resume, requests ignored while halted
    goto(20'h8);
    halt_req = 1'b1; fetch_ready = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_state", state, 32'h2);
    chk("halt_pc", pc, 32'h8);
    chk("halt_fv", fetch_valid, 32'h0);
    branch_taken = 1'b1; branch_target = 20'h40;
    tick();
    branch_taken = 1'b0;
    chk("halt_ign_st", state, 32'h2);
    chk("halt_ign_pc", pc, 32'h8);
    resume = 1'b1;
    tick();
    resume = 1'b0; fetch_ready = 1'b0;
    chk("res_state", state, 32'h0);
    chk("res_pc", pc, 32'h8);

    // Stall freezes a branch
    stall = 1'b1; branch_taken = 1'b1; branch_target = 20'h40; fetch_ready = 1'b1;
    #1 chk("stall_next", pc_next, 32'h8);
    tick();
    chk("stall_pc", pc, 32'h8);
    chk("stall_state", state, 32'h0);
    clear_req(); fetch_ready = 1'b0;

    // Wrap at the top of the address space
    goto(20'hFFFFC);
    chk("wrap_plus", pc_plus, 32'h0);
    fetch_ready = 1'b1;
    tick(); chk("wrap_pc", pc, 32'h0);
    tick(); chk("wrap_pc2", pc, 32'h4);
    fetch_ready = 1'b0;

    // Trap taken from HALT
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("ht_halt", state, 32'h2);
    trap_req = 1'b1;
    tick();
    trap_req = 1'b0;
    chk("ht_pc", pc, 32'h100);
    chk("ht_epc", epc, 32'h4);
    chk("ht_state", state, 32'h1);
    tick();

    // Reset during FLUSH
    branch_taken = 1'b1; branch_target = 20'h40;
    tick();
    branch_taken = 1'b0;
    chk("rf_flush", state, 32'h1);
    #2 rst = 1'b1;
    #1 chk("rf_pc", pc, 32'h0);
    chk("rf_state", state, 32'h0);
    chk("rf_epc", epc, 32'h0);
    tick();
    rst = 1'b0;
    chk("rf_fv", fetch_valid, 32'h1);

    // Reset during HALT
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("rh_halt", state, 32'h2);
    #2 rst = 1'b1;
    #1 chk("rh_state", state, 32'h0);
    tick();
    rst = 1'b0;
    chk("rh_fv", fetch_valid, 32'h1);
    tick();
    chk("rh_run", state, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
